// File: rtl/mem_perf_monitor.sv
// rtl/mem_perf_monitor.sv - request/reply latency and error monitor for a cached memory port
// Optional read-data compare is built when MEM_PERF_MONITOR_DATACHK_EN is defined.
module mem_perf_monitor #(
    parameter int CNT_W    = 32,
    parameter int LAT_W    = 8,
    parameter int HIT_MAX  = 2,
    parameter int MISS_MIN = 3,
    parameter int MISS_MAX = 20,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             Rd,
    input  logic             Wr,
    input  logic             Done,
    input  logic             CacheHit,
    input  logic [15:0]      DataOut,
    input  logic [15:0]      DataRef,
    output logic [CNT_W-1:0] n_requests,
    output logic [CNT_W-1:0] n_replies,
    output logic [CNT_W-1:0] n_hits,
    output logic [CNT_W-1:0] n_lat_err,
    output logic [CNT_W-1:0] n_data_err,
    output logic [CNT_W-1:0] n_drop,
    output logic [CNT_W-1:0] n_proto_err,
    output logic [LAT_W-1:0] cur_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic             busy,
    output logic             error
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_SAT    = {LAT_W{1'b1}};
    localparam logic [LAT_W-1:0] HIT_MAX_L  = LAT_W'(HIT_MAX);
    localparam logic [LAT_W-1:0] MISS_MIN_L = LAT_W'(MISS_MIN);
    localparam logic [LAT_W-1:0] MISS_MAX_L = LAT_W'(MISS_MAX);
    localparam logic [LAT_W-1:0] TIMEOUT_L  = LAT_W'(TIMEOUT);

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_inc;
    logic [LAT_W-1:0] lat_val;
    logic [1:0]       op;
    logic             done_rd;
    logic             ev_req;
    logic             ev_reply;
    logic             ev_hit;
    logic             ev_lat_err;
    logic             ev_drop;
    logic             ev_proto;
    logic             ev_data_err;

    assign lat_inc = (lat_cnt == LAT_SAT) ? lat_cnt : lat_cnt + LAT_ONE;
    assign busy    = (state == BUSY);

    // lat_val is the latency this edge would report: 1 on the issue edge, lat_cnt+1 while busy.
    always_comb begin
        ev_req     = 1'b0;
        ev_reply   = 1'b0;
        ev_hit     = 1'b0;
        ev_lat_err = 1'b0;
        ev_drop    = 1'b0;
        ev_proto   = 1'b0;
        lat_val    = lat_inc;
        done_rd    = op[1];
        case (state)
            IDLE: begin
                lat_val = LAT_ONE;
                done_rd = Rd;
                if (Rd && Wr) begin
                    ev_proto = 1'b1;
                end else if (Rd || Wr) begin
                    ev_req   = 1'b1;
                    ev_reply = Done;
                end else begin
                    ev_proto = Done;
                end
            end
            BUSY: begin
                ev_proto = (Rd || Wr) && ({Rd, Wr} != op);
                if (Done) begin
                    ev_reply = 1'b1;
                end else if (!(Rd || Wr) || (lat_inc >= TIMEOUT_L)) begin
                    ev_drop = 1'b1;
                end
            end
            default: ;
        endcase
        if (ev_reply) begin
            ev_hit     = CacheHit;
            ev_lat_err = CacheHit ? (lat_val > HIT_MAX_L)
                                  : ((lat_val < MISS_MIN_L) || (lat_val > MISS_MAX_L));
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

`ifdef MEM_PERF_MONITOR_DATACHK_EN
    assign ev_data_err = ev_reply && done_rd && (DataOut != DataRef);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_data_err <= '0;
        end else if (clr) begin
            n_data_err <= '0;
        end else begin
            n_data_err <= sat_inc(n_data_err, ev_data_err);
        end
    end
`else
    logic data_unused;
    assign data_unused = ^{DataOut, DataRef, done_rd};
    assign ev_data_err = 1'b0;
    assign n_data_err  = '0;
`endif

    // clr only touches the statistics; the request tracker keeps running through it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            op          <= '0;
            n_requests  <= '0;
            n_replies   <= '0;
            n_hits      <= '0;
            n_lat_err   <= '0;
            n_drop      <= '0;
            n_proto_err <= '0;
            cur_lat     <= '0;
            max_lat     <= '0;
            error       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ev_req) begin
                        lat_cnt <= LAT_ONE;
                        op      <= {Rd, Wr};
                        if (!Done) state <= BUSY;
                    end
                end
                BUSY: begin
                    lat_cnt <= lat_inc;
                    if (Rd || Wr) op <= {Rd, Wr};
                    if (ev_reply || ev_drop) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (clr) begin
                n_requests  <= '0;
                n_replies   <= '0;
                n_hits      <= '0;
                n_lat_err   <= '0;
                n_drop      <= '0;
                n_proto_err <= '0;
                cur_lat     <= '0;
                max_lat     <= '0;
                error       <= 1'b0;
            end else begin
                n_requests  <= sat_inc(n_requests, ev_req);
                n_replies   <= sat_inc(n_replies, ev_reply);
                n_hits      <= sat_inc(n_hits, ev_hit);
                n_lat_err   <= sat_inc(n_lat_err, ev_lat_err);
                n_drop      <= sat_inc(n_drop, ev_drop);
                n_proto_err <= sat_inc(n_proto_err, ev_proto);
                if (ev_reply) begin
                    cur_lat <= lat_val;
                    if (lat_val > max_lat) max_lat <= lat_val;
                end
                if (ev_lat_err || ev_drop || ev_proto || ev_data_err) error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_perf_monitor.sv
// tb/tb_mem_perf_monitor.sv - self-checking bench for mem_perf_monitor (directed table + random vs model)
module tb_mem_perf_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        Rd = 1'b0;
    logic        Wr = 1'b0;
    logic        Done = 1'b0;
    logic        CacheHit = 1'b0;
    logic [15:0] DataOut = 16'h0;
    logic [15:0] DataRef = 16'h0;
    logic [31:0] n_requests, n_replies, n_hits, n_lat_err, n_data_err, n_drop, n_proto_err;
    logic [7:0]  cur_lat, max_lat;
    logic        busy, error;

    int checks = 0;
    int failures = 0;

`ifdef MEM_PERF_MONITOR_DATACHK_EN
    localparam int DCHK = 1;
`else
    localparam int DCHK = 0;
`endif

    always #5 clk = ~clk;

    mem_perf_monitor dut (
        .clk(clk), .rst(rst), .clr(clr), .Rd(Rd), .Wr(Wr), .Done(Done), .CacheHit(CacheHit),
        .DataOut(DataOut), .DataRef(DataRef),
        .n_requests(n_requests), .n_replies(n_replies), .n_hits(n_hits), .n_lat_err(n_lat_err),
        .n_data_err(n_data_err), .n_drop(n_drop), .n_proto_err(n_proto_err),
        .cur_lat(cur_lat), .max_lat(max_lat), .busy(busy), .error(error)
    );

    // Reference model: one open request with its age, counters as plain integers.
    bit         m_open;
    int         m_age;
    logic [1:0] m_ops;
    int m_req, m_rep, m_hit, m_lat, m_data, m_drop, m_proto, m_cur, m_max;
    bit m_err;

    task automatic model_reset();
        m_open = 0; m_age = 0; m_ops = 2'b00;
        m_req = 0; m_rep = 0; m_hit = 0; m_lat = 0; m_data = 0; m_drop = 0; m_proto = 0;
        m_cur = 0; m_max = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic rd, input logic wr, input logic done, input logic hit,
                              input logic [15:0] dout, input logic [15:0] dref, input logic c);
        int d_req = 0, d_rep = 0, d_hit = 0, d_lat = 0, d_data = 0, d_drop = 0, d_proto = 0;
        int lat = 0;
        bit is_read = 0;
        if (!m_open) begin
            if (rd && wr) d_proto = 1;
            else if (rd || wr) begin
                d_req = 1; m_ops = {rd, wr}; m_age = 1;
                if (done) begin d_rep = 1; lat = 1; is_read = rd; end
                else m_open = 1;
            end else if (done) d_proto = 1;
        end else begin
            is_read = m_ops[1];
            if ((rd || wr) && ({rd, wr} != m_ops)) d_proto = 1;
            if (rd || wr) m_ops = {rd, wr};
            m_age = (m_age < 255) ? m_age + 1 : 255;
            if (done) begin d_rep = 1; lat = m_age; m_open = 0; end
            else if (!rd && !wr) begin d_drop = 1; m_open = 0; end
            else if (m_age >= 255) begin d_drop = 1; m_open = 0; end
        end
        if (d_rep != 0) begin
            if (hit) begin
                d_hit = 1;
                if (lat > 2) d_lat = 1;
            end else if (lat < 3 || lat > 20) d_lat = 1;
            if (DCHK != 0 && is_read && dout != dref) d_data = 1;
        end
        if (c) begin
            m_req = 0; m_rep = 0; m_hit = 0; m_lat = 0; m_data = 0; m_drop = 0; m_proto = 0;
            m_cur = 0; m_max = 0; m_err = 0;
        end else begin
            m_req += d_req; m_rep += d_rep; m_hit += d_hit; m_lat += d_lat;
            m_data += d_data; m_drop += d_drop; m_proto += d_proto;
            if (d_rep != 0) begin
                m_cur = lat;
                if (lat > m_max) m_max = lat;
            end
            if (d_lat + d_data + d_drop + d_proto != 0) m_err = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_edge(input logic rd, input logic wr, input logic done, input logic hit,
                              input logic [15:0] dout, input logic [15:0] dref, input logic c);
        Rd = rd; Wr = wr; Done = done; CacheHit = hit; DataOut = dout; DataRef = dref; clr = c;
        @(posedge clk);
        if (rst) model_edge(rd, wr, done, hit, dout, dref, c);
        else model_reset();
        #1;
    endtask

    task automatic idle_edge();
        drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic clr_edge();
        drive_edge(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    task automatic do_txn(input logic rd, input logic wr, input logic hit, input int lat,
                          input logic [15:0] dout, input logic [15:0] dref);
        for (int e = 1; e <= lat; e++) drive_edge(rd, wr, e == lat, hit, dout, dref, 1'b0);
        idle_edge();
    endtask

    task automatic check_zero(input string p);
        chk({p, "_requests"}, n_requests, 0);
        chk({p, "_replies"}, n_replies, 0);
        chk({p, "_hits"}, n_hits, 0);
        chk({p, "_lat_err"}, n_lat_err, 0);
        chk({p, "_data_err"}, n_data_err, 0);
        chk({p, "_drop"}, n_drop, 0);
        chk({p, "_proto"}, n_proto_err, 0);
        chk({p, "_cur_lat"}, 32'(cur_lat), 0);
        chk({p, "_max_lat"}, 32'(max_lat), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_error"}, 32'(error), 0);
    endtask

    task automatic check_model(input int i);
        chk($sformatf("rnd%0d_requests", i), n_requests, m_req);
        chk($sformatf("rnd%0d_replies", i), n_replies, m_rep);
        chk($sformatf("rnd%0d_hits", i), n_hits, m_hit);
        chk($sformatf("rnd%0d_lat_err", i), n_lat_err, m_lat);
        chk($sformatf("rnd%0d_data_err", i), n_data_err, m_data);
        chk($sformatf("rnd%0d_drop", i), n_drop, m_drop);
        chk($sformatf("rnd%0d_proto", i), n_proto_err, m_proto);
        chk($sformatf("rnd%0d_cur_lat", i), 32'(cur_lat), m_cur);
        chk($sformatf("rnd%0d_max_lat", i), 32'(max_lat), m_max);
        chk($sformatf("rnd%0d_busy", i), 32'(busy), 32'(m_open));
        chk($sformatf("rnd%0d_error", i), 32'(error), 32'(m_err));
    endtask

    typedef struct {
        logic rd;
        logic wr;
        logic hit;
        int   lat;
        int   lat_err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lat, exp_hit, exp_max, te;
        bit seen;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 2, 0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 21, 1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 2, 1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1, 0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 3, 1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 3, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 20, 0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 2, 0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1, 1};

        repeat (3) idle_edge();
        rst = 1'b1;
        check_zero("reset");

        exp_lat = 0; exp_hit = 0; exp_max = 0;
        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].rd, tbl[i].wr, tbl[i].hit, tbl[i].lat, 16'h0, 16'h0);
            exp_lat += tbl[i].lat_err;
            exp_hit += int'(tbl[i].hit);
            if (tbl[i].lat > exp_max) exp_max = tbl[i].lat;
            chk($sformatf("tbl%0d_requests", i), n_requests, i + 1);
            chk($sformatf("tbl%0d_replies", i), n_replies, i + 1);
            chk($sformatf("tbl%0d_hits", i), n_hits, exp_hit);
            chk($sformatf("tbl%0d_cur_lat", i), 32'(cur_lat), tbl[i].lat);
            chk($sformatf("tbl%0d_max_lat", i), 32'(max_lat), exp_max);
            chk($sformatf("tbl%0d_lat_err", i), n_lat_err, exp_lat);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 0);
            chk($sformatf("tbl%0d_error", i), 32'(error), 32'(exp_lat != 0));
        end

        clr_edge();
        check_zero("clr");

        for (int e = 1; e <= 4; e++) drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("drop_busy_before", 32'(busy), 1);
        idle_edge();
        chk("drop_count", n_drop, 1);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_cur_lat", 32'(cur_lat), 0);
        chk("drop_replies", n_replies, 0);
        chk("drop_error", 32'(error), 1);

        seen = 0; te = 0;
        for (int e = 1; e <= 300; e++) begin
            drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            te = e;
            if (!busy) begin seen = 1; break; end
        end
        idle_edge();
        chk("timeout_seen", 32'(seen), 1);
        chk("timeout_edge", te, 255);
        chk("timeout_drop", n_drop, 2);
        chk("timeout_requests", n_requests, 2);
        chk("timeout_cur_lat", 32'(cur_lat), 0);

        clr_edge();
        drive_edge(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        drive_edge(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        idle_edge();
        chk("proto_count", n_proto_err, 2);
        chk("proto_requests", n_requests, 0);
        chk("proto_busy", 32'(busy), 0);
        chk("proto_error", 32'(error), 1);

        clr_edge();
        do_txn(1'b1, 1'b0, 1'b1, 1, 16'h1234, 16'h1235);
        chk("data_rd_err", n_data_err, DCHK);
        chk("data_rd_error", 32'(error), DCHK);
        do_txn(1'b0, 1'b1, 1'b1, 1, 16'h1234, 16'h1235);
        chk("data_wr_err", n_data_err, DCHK);
        chk("data_requests", n_requests, 2);

        for (int e = 1; e <= 7; e++) drive_edge(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        chk("prerst_busy", 32'(busy), 1);
        chk("prerst_requests", n_requests, 3);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        idle_edge();
        rst = 1'b1;
        repeat (3) idle_edge();
        chk("postrst_drop", n_drop, 0);
        chk("postrst_busy", 32'(busy), 0);

        drive_edge(1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
        chk("clrcpl_req_before", n_requests, 1);
        drive_edge(1'b1, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b1);
        idle_edge();
        check_zero("clrcpl");

        rst = 1'b0;
        idle_edge();
        rst = 1'b1;
        for (int i = 0; i < 250; i++) begin
            int k, lat, flip, n;
            logic rd, hit, r, dn;
            logic [15:0] dout, dref;
            k    = int'($urandom_range(0, 9));
            rd   = 1'($urandom_range(0, 1));
            hit  = 1'($urandom_range(0, 1));
            dn   = 1'($urandom_range(0, 1));
            dout = 16'($urandom);
            dref = ($urandom_range(0, 1) == 0) ? dout : dout ^ 16'h0001;
            if (k <= 5) begin
                lat  = int'($urandom_range(1, 24));
                flip = (lat > 2 && $urandom_range(0, 7) == 0) ? int'($urandom_range(2, lat - 1)) : 0;
                for (int e = 1; e <= lat; e++) begin
                    r = (flip != 0 && e >= flip) ? !rd : rd;
                    drive_edge(r, !r, e == lat, hit, dout, dref, 1'b0);
                end
                idle_edge();
            end else if (k == 6) begin
                n = int'($urandom_range(1, 10));
                for (int e = 1; e <= n; e++) drive_edge(rd, !rd, 1'b0, hit, dout, dref, 1'b0);
                idle_edge();
            end else if (k == 7) begin
                drive_edge(1'b0, 1'b0, 1'b1, hit, dout, dref, 1'b0);
            end else if (k == 8) begin
                drive_edge(1'b1, 1'b1, dn, hit, dout, dref, 1'b0);
            end else begin
                drive_edge(rd, 1'b0, dn, hit, dout, dref, 1'b1);
                idle_edge();
            end
            check_model(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
